rs_station: RTL and testbench
=============================

Name: rs_station

Overview:
- Reservation station sitting between the decode stage and the ALU.
- Receives dispatched instructions on the decode→RS assignment interface: op, imm, operands, operand tags, PC and destination ROB tag.
- Holds up to ENTRIES instructions and snoops the common data bus (CDB) to resolve pending operand tags.
- Issues the oldest-slot ready instruction to the ALU, one per cycle, and raises a full flag that inhibits decode `ena`.

Parameters:
- ENTRIES, 8: number of station slots (power of two, ≥4).
- IDX_W, 3: log2(ENTRIES).
- ROB_W, 4: ROB tag width. Tag 0 (`ZERO_ROB`) means "operand value present".
- DATA_W, 32: operand, immediate and PC width.
- OP_W, 6: width of the internal operation code (`OPERATION_BUS`).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_assign_ena  in  1  decode dispatch valid
- in_op  in  OP_W  operation code
- in_imm  in  DATA_W  immediate
- in_operand1  in  DATA_W  source value 1
- in_operand2  in  DATA_W  source value 2
- in_tag1  in  ROB_W  pending producer tag for source 1
- in_tag2  in  ROB_W  pending producer tag for source 2
- in_pc  in  DATA_W  instruction PC
- in_rd_rob_tag  in  ROB_W  destination ROB entry
- in_cdb_valid  in  1  CDB broadcast valid
- in_cdb_tag  in  ROB_W  CDB producer tag
- in_cdb_value  in  DATA_W  CDB result
- in_rollback  in  1  misprediction flush
- out_full  out  1  station cannot accept a further dispatch
- out_alu_ena  out  1  issue valid
- out_alu_op  out  OP_W  issued op
- out_alu_a  out  DATA_W  issued operand 1
- out_alu_b  out  DATA_W  issued operand 2
- out_alu_imm  out  DATA_W  issued immediate
- out_alu_pc  out  DATA_W  issued PC
- out_alu_rob_tag  out  ROB_W  issued destination tag

Behaviour:
- Reset (rst=1 at posedge):
  - All entry valid bits cleared.
  - out_alu_ena=0, out_full=0.
  - All other ALU outputs driven to 0.
  - Reset has priority over every other input.
- Entry fields: valid, op, imm, pc, rob_tag, v1, v2, t1, t2. An entry is ready when valid && t1==0 && t2==0.
- Dispatch:
  - When in_assign_ena=1 and in_op != `NOP`, the instruction is written into the lowest-index slot that is free at the start of the cycle.
  - `NOP` dispatches are dropped.
- Dispatch-time CDB capture:
  - If in_cdb_valid and in_tagX != 0 and in_tagX == in_cdb_tag in the dispatch cycle, the entry stores vX=in_cdb_value and tX=0.
- Wake-up:
  - Each cycle with in_cdb_valid=1, every valid entry with tX == in_cdb_tag (tX != 0) loads vX<=in_cdb_value and tX<=0.
  - An entry can capture both operands from one broadcast.
- Select and issue:
  - Readiness is evaluated on registered entry state.
  - The lowest-index ready entry is issued: its fields are registered onto out_alu_* with out_alu_ena=1, and its valid bit is cleared at the same edge.
  - If no entry is ready, out_alu_ena=0 and the other outputs hold their last values.
  - Latency: dispatch with no pending tags at edge N → out_alu_ena=1 after edge N+1. CDB wake-up at edge N → issue after edge N+1.
- Freed slots: a slot freed by issue is reusable from the next cycle, not the same cycle.
- out_full:
  - Registered; equals 1 when occupancy after the edge is ≥ ENTRIES-1.
  - This covers the one dispatch already in flight from the registered decode stage.
  - A dispatch arriving with zero free slots is an illegal protocol state: a verification assertion fires, and the dispatch is dropped.
- Rollback:
  - in_rollback=1 clears all valid bits and forces out_alu_ena<=0 and out_full<=0 at that edge.
  - A dispatch or CDB broadcast in the same cycle is ignored.
  - Priority order: rst > in_rollback > issue, wake-up and dispatch.
- Simultaneous events: dispatch, wake-up and issue on distinct slots all take effect in one cycle.

Optional Feature:
- Macro: RS_DUAL_CDB_EN.
- When defined:
  - Adds second-broadcast ports in_cdb2_valid, in_cdb2_tag and in_cdb2_value (the load-queue result bus).
  - Both buses are matched for wake-up and for dispatch-time capture.
  - If both buses match the same tag, CDB1 wins.
- When undefined: single CDB only, and the ports do not exist.

Decomposition:
- Shared constants in constant.v: `ZERO_ROB`, `NOP`, `OPERATION_BUS`, `DATA_WIDTH`, `ROB_WIDTH`, plus a new `RS_ENTRIES`.
- One sub-module, rs_select: a parameterised lowest-index priority encoder (vector in → index + found flag).
- rs_select is instantiated twice: once for the free slot and once for the ready slot.

Test Plan:
1. Reset; dispatch ADD, operand1=5, operand2=7, tags 0, rob_tag=2 → after next edge out_alu_ena=1, a=5, b=7, rob_tag=2; following cycle out_alu_ena=0.
2. Dispatch with tag1=3, operand2=1 → no issue; CDB tag=3, value=0x10 two cycles later → issue next cycle with a=0x10, b=1.
3. Dispatch with tag2=2 in the same cycle as CDB tag=2, value=0xAB → entry stored ready and issues next cycle with b=0xAB.
4. Seven dispatches all with tag1=5 → out_full=1 after the 7th edge; CDB tag=5 → entries issue one per cycle in slot order 0..6, and out_full drops after the first issue.
5. Three pending entries, then rollback → next cycle no valid entries, out_full=0, out_alu_ena=0; a later CDB for their tags produces no issue.
6. Ready entries in slots 0 and 3 → slot 0 issues first, slot 3 issues the next cycle. Under RS_DUAL_CDB_EN, CDB1 tag 4 and CDB2 tag 6 wake both operands of one entry in a single cycle.

Source files
------------

// File: rtl/rs_station_pkg.sv
// rs_station_pkg: shared widths, opcodes, entry layout and CDB snoop helper for the reservation station.
// Optional RS_DUAL_CDB_EN adds a second result bus; the helper always takes both buses.
package rs_station_pkg;
    localparam int DATA_W = 32;
    localparam int ROB_W = 4;
    localparam int OP_W = 6;
    localparam int RS_ENTRIES = 8;
    localparam logic [ROB_W-1:0] ZERO_ROB = '0;
    localparam logic [OP_W-1:0] NOP = '0;
    localparam logic [OP_W-1:0] OP_ADD = 6'd1;

    typedef struct packed {
        logic [ROB_W-1:0] t;
        logic [DATA_W-1:0] v;
    } opnd_t;

    typedef struct packed {
        logic valid;
        logic [OP_W-1:0] op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [ROB_W-1:0] rob;
        opnd_t o1;
        opnd_t o2;
    } rs_entry_t;

    // CDB1 is checked first so it wins when both buses carry the same tag.
    function automatic opnd_t snoop(input opnd_t o, input logic c1v, input logic [ROB_W-1:0] c1t,
                                    input logic [DATA_W-1:0] c1d, input logic c2v,
                                    input logic [ROB_W-1:0] c2t, input logic [DATA_W-1:0] c2d);
        return (o.t != ZERO_ROB && c1v && c1t == o.t) ? opnd_t'{t: ZERO_ROB, v: c1d} :
               (o.t != ZERO_ROB && c2v && c2t == o.t) ? opnd_t'{t: ZERO_ROB, v: c2d} : o;
    endfunction
endpackage

// File: rtl/rs_station_if.sv
// rs_station_if: dispatch, CDB, rollback and ALU issue signals of the reservation station.
// RS_DUAL_CDB_EN adds the second (load-queue) broadcast bus.
interface rs_station_if;
    import rs_station_pkg::*;
    logic in_assign_ena;
    logic [OP_W-1:0] in_op;
    logic [DATA_W-1:0] in_imm, in_operand1, in_operand2, in_pc;
    logic [ROB_W-1:0] in_tag1, in_tag2, in_rd_rob_tag;
    logic in_cdb_valid;
    logic [ROB_W-1:0] in_cdb_tag;
    logic [DATA_W-1:0] in_cdb_value;
`ifdef RS_DUAL_CDB_EN
    logic in_cdb2_valid;
    logic [ROB_W-1:0] in_cdb2_tag;
    logic [DATA_W-1:0] in_cdb2_value;
`endif
    logic in_rollback;
    logic out_full, out_alu_ena;
    logic [OP_W-1:0] out_alu_op;
    logic [DATA_W-1:0] out_alu_a, out_alu_b, out_alu_imm, out_alu_pc;
    logic [ROB_W-1:0] out_alu_rob_tag;

    modport master(
`ifdef RS_DUAL_CDB_EN
        output in_cdb2_valid, in_cdb2_tag, in_cdb2_value,
`endif
        output in_assign_ena, in_op, in_imm, in_operand1, in_operand2, in_tag1, in_tag2, in_pc,
        output in_rd_rob_tag, in_cdb_valid, in_cdb_tag, in_cdb_value, in_rollback,
        input out_full, out_alu_ena, out_alu_op, out_alu_a, out_alu_b, out_alu_imm, out_alu_pc,
        input out_alu_rob_tag
    );
    modport slave(
`ifdef RS_DUAL_CDB_EN
        input in_cdb2_valid, in_cdb2_tag, in_cdb2_value,
`endif
        input in_assign_ena, in_op, in_imm, in_operand1, in_operand2, in_tag1, in_tag2, in_pc,
        input in_rd_rob_tag, in_cdb_valid, in_cdb_tag, in_cdb_value, in_rollback,
        output out_full, out_alu_ena, out_alu_op, out_alu_a, out_alu_b, out_alu_imm, out_alu_pc,
        output out_alu_rob_tag
    );
endinterface

// File: rtl/rs_station_select.sv
// rs_select: lowest-index priority encoder returning the first set bit and a found flag.
module rs_select #(
    parameter int N = 8,
    parameter int W = 3
) (
    input logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic found
);
    always_comb begin
        idx = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_station.sv
// rs_station: reservation station between decode and ALU with CDB wake-up and oldest-slot issue.
// Define RS_DUAL_CDB_EN to snoop the second (load-queue) result bus as well.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int ENTRIES = RS_ENTRIES,
    parameter int IDX_W = $clog2(ENTRIES)
) (
    input logic clk,
    input logic rst,
    rs_station_if.slave bus
);
    rs_entry_t ent [ENTRIES];
    opnd_t w1 [ENTRIES];
    opnd_t w2 [ENTRIES];
    opnd_t d1, d2;
    logic [ENTRIES-1:0] free_vec, rdy_vec, nxt_valid;
    logic [IDX_W-1:0] free_idx, rdy_idx;
    logic free_found, rdy_found, disp_req, disp;
    logic c2_valid;
    logic [ROB_W-1:0] c2_tag;
    logic [DATA_W-1:0] c2_value;

`ifdef RS_DUAL_CDB_EN
    assign c2_valid = bus.in_cdb2_valid;
    assign c2_tag = bus.in_cdb2_tag;
    assign c2_value = bus.in_cdb2_value;
`else
    assign c2_valid = 1'b0;
    assign c2_tag = ZERO_ROB;
    assign c2_value = '0;
`endif

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w1[i] = snoop(ent[i].o1, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_value, c2_valid, c2_tag, c2_value);
            w2[i] = snoop(ent[i].o2, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_value, c2_valid, c2_tag, c2_value);
            free_vec[i] = !ent[i].valid;
            rdy_vec[i] = ent[i].valid && ent[i].o1.t == ZERO_ROB && ent[i].o2.t == ZERO_ROB;
        end
    end

    rs_select #(.N(ENTRIES), .W(IDX_W)) u_free (.vec(free_vec), .idx(free_idx), .found(free_found));
    rs_select #(.N(ENTRIES), .W(IDX_W)) u_rdy (.vec(rdy_vec), .idx(rdy_idx), .found(rdy_found));

    assign disp_req = bus.in_assign_ena && bus.in_op != NOP;
    assign disp = disp_req && free_found;
    assign d1 = snoop(opnd_t'{t: bus.in_tag1, v: bus.in_operand1}, bus.in_cdb_valid, bus.in_cdb_tag,
                      bus.in_cdb_value, c2_valid, c2_tag, c2_value);
    assign d2 = snoop(opnd_t'{t: bus.in_tag2, v: bus.in_operand2}, bus.in_cdb_valid, bus.in_cdb_tag,
                      bus.in_cdb_value, c2_valid, c2_tag, c2_value);

    // Occupancy after the edge drives the registered full flag.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++)
            nxt_valid[i] = (ent[i].valid && !(rdy_found && rdy_idx == IDX_W'(i))) || (disp && free_idx == IDX_W'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
            bus.out_alu_ena <= 1'b0;
            bus.out_full <= 1'b0;
            bus.out_alu_op <= '0;
            bus.out_alu_a <= '0;
            bus.out_alu_b <= '0;
            bus.out_alu_imm <= '0;
            bus.out_alu_pc <= '0;
            bus.out_alu_rob_tag <= '0;
        end else if (bus.in_rollback) begin
            for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
            bus.out_alu_ena <= 1'b0;
            bus.out_full <= 1'b0;
        end else begin
            assert (!(disp_req && !free_found));
            for (int i = 0; i < ENTRIES; i++) begin
                ent[i].o1 <= w1[i];
                ent[i].o2 <= w2[i];
            end
            if (disp)
                ent[free_idx] <= rs_entry_t'{valid: 1'b1, op: bus.in_op, imm: bus.in_imm, pc: bus.in_pc,
                                             rob: bus.in_rd_rob_tag, o1: d1, o2: d2};
            if (rdy_found) begin
                ent[rdy_idx].valid <= 1'b0;
                bus.out_alu_op <= ent[rdy_idx].op;
                bus.out_alu_a <= ent[rdy_idx].o1.v;
                bus.out_alu_b <= ent[rdy_idx].o2.v;
                bus.out_alu_imm <= ent[rdy_idx].imm;
                bus.out_alu_pc <= ent[rdy_idx].pc;
                bus.out_alu_rob_tag <= ent[rdy_idx].rob;
            end
            bus.out_alu_ena <= rdy_found;
            bus.out_full <= $countones(nxt_valid) >= ENTRIES - 1;
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// tb_rs_station: directed self-checking bench for rs_station with hand-computed expectations.
module tb_rs_station;
    import rs_station_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;

    rs_station_if bus ();
    rs_station dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.in_assign_ena = 1'b0;
        bus.in_op = NOP;
        bus.in_cdb_valid = 1'b0;
        bus.in_rollback = 1'b0;
`ifdef RS_DUAL_CDB_EN
        bus.in_cdb2_valid = 1'b0;
`endif
    endtask

    task automatic disp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t1, input logic [3:0] t2,
                        input logic [3:0] rob);
        bus.in_assign_ena = 1'b1;
        bus.in_op = OP_ADD;
        bus.in_imm = 32'h10 + 32'(rob);
        bus.in_operand1 = a;
        bus.in_operand2 = b;
        bus.in_tag1 = t1;
        bus.in_tag2 = t2;
        bus.in_pc = 32'h1000 + 32'(rob);
        bus.in_rd_rob_tag = rob;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        bus.in_cdb_valid = 1'b1;
        bus.in_cdb_tag = t;
        bus.in_cdb_value = v;
    endtask

    initial begin
        idle();
        bus.in_imm = '0;
        bus.in_operand1 = '0;
        bus.in_operand2 = '0;
        bus.in_tag1 = '0;
        bus.in_tag2 = '0;
        bus.in_pc = '0;
        bus.in_rd_rob_tag = '0;
        bus.in_cdb_tag = '0;
        bus.in_cdb_value = '0;
`ifdef RS_DUAL_CDB_EN
        bus.in_cdb2_tag = '0;
        bus.in_cdb2_value = '0;
`endif
        rst = 1'b1;
        disp(32'd1, 32'd1, 4'd0, 4'd0, 4'd1);
        step();
        step();
        chk("rst_ena", 32'(bus.out_alu_ena), 0);
        chk("rst_full", 32'(bus.out_full), 0);
        chk("rst_a", bus.out_alu_a, 0);
        chk("rst_rob", 32'(bus.out_alu_rob_tag), 0);
        chk("rst_pc", bus.out_alu_pc, 0);
        rst = 1'b0;
        idle();
        step();
        chk("idle_ena", 32'(bus.out_alu_ena), 0);

        disp(32'd5, 32'd7, 4'd0, 4'd0, 4'd2);
        step();
        idle();
        chk("t1_lat_ena", 32'(bus.out_alu_ena), 0);
        step();
        chk("t1_ena", 32'(bus.out_alu_ena), 1);
        chk("t1_a", bus.out_alu_a, 5);
        chk("t1_b", bus.out_alu_b, 7);
        chk("t1_rob", 32'(bus.out_alu_rob_tag), 2);
        chk("t1_op", 32'(bus.out_alu_op), 32'(OP_ADD));
        chk("t1_pc", bus.out_alu_pc, 32'h1002);
        chk("t1_imm", bus.out_alu_imm, 32'h12);
        step();
        chk("t1_ena_off", 32'(bus.out_alu_ena), 0);
        chk("t1_hold_a", bus.out_alu_a, 5);

        disp(32'h99, 32'd1, 4'd3, 4'd0, 4'd4);
        step();
        idle();
        chk("t2_wait0", 32'(bus.out_alu_ena), 0);
        step();
        chk("t2_wait1", 32'(bus.out_alu_ena), 0);
        cdb(4'd3, 32'h10);
        step();
        idle();
        chk("t2_wake", 32'(bus.out_alu_ena), 0);
        step();
        chk("t2_ena", 32'(bus.out_alu_ena), 1);
        chk("t2_a", bus.out_alu_a, 32'h10);
        chk("t2_b", bus.out_alu_b, 1);
        chk("t2_rob", 32'(bus.out_alu_rob_tag), 4);

        disp(32'd9, 32'd0, 4'd0, 4'd2, 4'd5);
        cdb(4'd2, 32'hAB);
        step();
        idle();
        chk("t3_lat", 32'(bus.out_alu_ena), 0);
        step();
        chk("t3_ena", 32'(bus.out_alu_ena), 1);
        chk("t3_a", bus.out_alu_a, 9);
        chk("t3_b", bus.out_alu_b, 32'hAB);
        chk("t3_rob", 32'(bus.out_alu_rob_tag), 5);

        for (int i = 0; i < 7; i++) begin
            disp(32'd0, 32'(i), 4'd5, 4'd0, 4'(i + 1));
            step();
            chk($sformatf("t4_full%0d", i), 32'(bus.out_full), (i == 6) ? 1 : 0);
        end
        idle();
        chk("t4_noissue", 32'(bus.out_alu_ena), 0);
        cdb(4'd5, 32'h55);
        step();
        idle();
        chk("t4_wake_full", 32'(bus.out_full), 1);
        chk("t4_wake_ena", 32'(bus.out_alu_ena), 0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("t4_ena%0d", i), 32'(bus.out_alu_ena), 1);
            chk($sformatf("t4_b%0d", i), bus.out_alu_b, 32'(i));
            chk($sformatf("t4_rob%0d", i), 32'(bus.out_alu_rob_tag), 32'(i + 1));
            if (i == 0) begin
                chk("t4_a0", bus.out_alu_a, 32'h55);
                chk("t4_full_drop", 32'(bus.out_full), 0);
            end
        end
        step();
        chk("t4_drained", 32'(bus.out_alu_ena), 0);

        disp(32'd0, 32'd1, 4'd6, 4'd0, 4'd1);
        step();
        disp(32'd0, 32'd2, 4'd7, 4'd0, 4'd2);
        step();
        disp(32'd3, 32'd0, 4'd0, 4'd8, 4'd3);
        step();
        disp(32'd4, 32'd4, 4'd0, 4'd0, 4'd4);
        step();
        disp(32'd7, 32'd7, 4'd0, 4'd0, 4'd9);
        cdb(4'd6, 32'h1);
        bus.in_rollback = 1'b1;
        step();
        idle();
        chk("t5_rb_ena", 32'(bus.out_alu_ena), 0);
        chk("t5_rb_full", 32'(bus.out_full), 0);
        step();
        chk("t5_no_disp", 32'(bus.out_alu_ena), 0);
        cdb(4'd7, 32'h2);
        step();
        cdb(4'd8, 32'h3);
        step();
        cdb(4'd6, 32'h1);
        step();
        idle();
        step();
        chk("t5_no_issue", 32'(bus.out_alu_ena), 0);
        chk("t5_hold_rob", 32'(bus.out_alu_rob_tag), 7);

        disp(32'd0, 32'h60, 4'd9, 4'd0, 4'd1);
        step();
        disp(32'd0, 32'h61, 4'd10, 4'd0, 4'd2);
        step();
        disp(32'd0, 32'h62, 4'd11, 4'd0, 4'd3);
        step();
        disp(32'd0, 32'h63, 4'd9, 4'd0, 4'd4);
        step();
        idle();
        cdb(4'd9, 32'h9);
        step();
        idle();
        chk("t6_wake", 32'(bus.out_alu_ena), 0);
        step();
        chk("t6_s0_ena", 32'(bus.out_alu_ena), 1);
        chk("t6_s0_rob", 32'(bus.out_alu_rob_tag), 1);
        chk("t6_s0_b", bus.out_alu_b, 32'h60);
        step();
        chk("t6_s3_ena", 32'(bus.out_alu_ena), 1);
        chk("t6_s3_rob", 32'(bus.out_alu_rob_tag), 4);
        chk("t6_s3_b", bus.out_alu_b, 32'h63);
        step();
        chk("t6_done", 32'(bus.out_alu_ena), 0);
        bus.in_rollback = 1'b1;
        step();
        idle();
        chk("t6_rb_full", 32'(bus.out_full), 0);

`ifdef RS_DUAL_CDB_EN
        disp(32'd0, 32'd0, 4'd4, 4'd6, 4'd7);
        step();
        idle();
        cdb(4'd4, 32'h44);
        bus.in_cdb2_valid = 1'b1;
        bus.in_cdb2_tag = 4'd6;
        bus.in_cdb2_value = 32'h66;
        step();
        idle();
        step();
        chk("dual_ena", 32'(bus.out_alu_ena), 1);
        chk("dual_a", bus.out_alu_a, 32'h44);
        chk("dual_b", bus.out_alu_b, 32'h66);
        disp(32'd0, 32'd0, 4'd12, 4'd12, 4'd8);
        step();
        idle();
        cdb(4'd12, 32'h11);
        bus.in_cdb2_valid = 1'b1;
        bus.in_cdb2_tag = 4'd12;
        bus.in_cdb2_value = 32'h22;
        step();
        idle();
        step();
        chk("dual_prio_ena", 32'(bus.out_alu_ena), 1);
        chk("dual_prio_a", bus.out_alu_a, 32'h11);
        chk("dual_prio_b", bus.out_alu_b, 32'h11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
